// File: rtl/simplex8_pkg.sv
// simplex8_pkg: definitions shared by the simplex8 sequencer and ALU.
//   - opcode constants (IR[7:4])
//   - sequencer FSM state encoding
//   - ACC_SRC mux codes
//   - FLAGS bit indices (same byte the ALU produces)
//   - ctrl_t: the control vector driven toward the ALU / register file
package simplex8_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_SHR  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LDA  = 4'h6;
   localparam logic [3:0] OP_STA  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_BRF  = 4'hA;
   localparam logic [3:0] OP_BRNF = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hC;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_TFETCH = 3'd4,
      ST_TARGET = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_REG = 2'd1;
   localparam logic [1:0] SRC_IMM = 2'd2;

   localparam int FLAG_ONE   = 0;
   localparam int FLAG_EQ    = 1;
   localparam int FLAG_LT    = 2;
   localparam int FLAG_GT    = 3;
   localparam int FLAG_CARRY = 4;
   localparam int FLAG_ANY   = 6;

   typedef struct packed {
      logic       add;
      logic       sub;
      logic       shift;
      logic       op_or;
      logic       op_and;
      logic       set_flags;
      logic       reg_we;
      logic       acc_we;
      logic [1:0] acc_src;
      logic       halted;
   } ctrl_t;

   // Opcodes that go through the two-cycle EXEC/WB ALU path.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHR) ||
             (op == OP_OR)  || (op == OP_AND);
   endfunction

endpackage

// File: rtl/simplex8_decode.sv
// simplex8_decode: combinational decode of (FSM state, IR opcode) into the
// control vector. Pure Moore decode: no INSTR/FLAGS inputs reach here.
//   state   in  current sequencer state
//   op      in  IR[7:4]
//   ctrl    out strobes, SET_FLAGS, REG_WE, ACC_WE, ACC_SRC, HALTED
//   opnd_en out REG_SEL is meaningful (EXEC and WB)
//   imm_en  out IMM is meaningful (EXEC)
import simplex8_pkg::*;

module simplex8_decode (
   input  state_t     state,
   input  logic [3:0] op,
   output ctrl_t      ctrl,
   output logic       opnd_en,
   output logic       imm_en
);

   // The same one-hot strobe is asserted in EXEC and held through WB so the
   // ALU result stays stable while the accumulator captures it.
   function automatic ctrl_t with_strobe(input ctrl_t c, input logic [3:0] o);
      ctrl_t r;
      r = c;
      case (o)
         OP_ADD:  r.add    = 1'b1;
         OP_SUB:  r.sub    = 1'b1;
         OP_SHR:  r.shift  = 1'b1;
         OP_OR:   r.op_or  = 1'b1;
         OP_AND:  r.op_and = 1'b1;
         default: ;
      endcase
      return r;
   endfunction

   always_comb begin
      ctrl    = '0;
      opnd_en = 1'b0;
      imm_en  = 1'b0;
      case (state)
         ST_EXEC: begin
            opnd_en = 1'b1;
            imm_en  = 1'b1;
            if (is_alu_op(op)) begin
               ctrl           = with_strobe(ctrl, op);
               ctrl.set_flags = 1'b1;
            end else begin
               case (op)
                  OP_CMP: ctrl.set_flags = 1'b1;
                  OP_LDA: begin
                     ctrl.acc_we  = 1'b1;
                     ctrl.acc_src = SRC_REG;
                  end
                  OP_LDI: begin
                     ctrl.acc_we  = 1'b1;
                     ctrl.acc_src = SRC_IMM;
                  end
                  OP_STA: ctrl.reg_we = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_WB: begin
            opnd_en      = 1'b1;
            ctrl         = with_strobe(ctrl, op);
            ctrl.acc_we  = 1'b1;
            ctrl.acc_src = SRC_ALU;
         end
         ST_HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/simplex8_control.sv
// simplex8_control: fetch/decode/execute sequencer for the simplex8 core.
// Holds PC, IR and the FSM; control outputs are decoded from registered
// state only.
//   CLK, RST_N        clock, asynchronous active-low reset
//   PC_ADDR           program memory address (INSTR returns one cycle later)
//   INSTR             instruction / branch target byte
//   FLAGS             ALU flag byte, sampled in TARGET
//   ADD..AND          one-hot ALU op strobes
//   SET_FLAGS         ALU flag-update enable
//   REG_SEL           register index (ALU operand / store target)
//   REG_WE, ACC_WE    register file / accumulator write enables
//   ACC_SRC           accumulator source: ALU, register, immediate
//   IMM               zero-extended 4-bit immediate
//   HALTED            high in HALT
//   dbg_state         current FSM state, for observation
import simplex8_pkg::*;

module simplex8_control #(
   parameter int PC_W      = 8,
   parameter int REG_IDX_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   output logic [PC_W-1:0]      PC_ADDR,
   input  logic [7:0]           INSTR,
   input  logic [7:0]           FLAGS,
   output logic                 ADD,
   output logic                 SUB,
   output logic                 SHIFT,
   output logic                 OR,
   output logic                 AND,
   output logic                 SET_FLAGS,
   output logic [REG_IDX_W-1:0] REG_SEL,
   output logic                 REG_WE,
   output logic                 ACC_WE,
   output logic [1:0]           ACC_SRC,
   output logic [7:0]           IMM,
   output logic                 HALTED,
   output state_t               dbg_state
);

   state_t          state, state_n;
   logic [PC_W-1:0] pc;
   logic [7:0]      ir;
   logic            taken;
   ctrl_t           ctrl;
   logic            opnd_en, imm_en;

   // BRNF inverts the sense of the selected flag bit.
   assign taken = FLAGS[ir[2:0]] ^ (ir[7:4] == OP_BRNF);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_FETCH;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_n;
         case (state)
            ST_DECODE: begin
               ir <= INSTR;
               pc <= pc + PC_W'(1);
            end
            // Not taken skips over the target byte.
            ST_TARGET: pc <= taken ? PC_W'(INSTR) : pc + PC_W'(1);
            default: ;
         endcase
      end
   end

   // INSTR steers the next state in DECODE only; it never reaches outputs.
   always_comb begin
      state_n = state;
      case (state)
         ST_FETCH:  state_n = ST_DECODE;
         ST_DECODE: begin
            case (INSTR[7:4])
               OP_ADD, OP_SUB, OP_SHR, OP_OR, OP_AND,
               OP_LDA, OP_STA, OP_LDI, OP_CMP: state_n = ST_EXEC;
               OP_BRF, OP_BRNF:                state_n = ST_TFETCH;
               OP_HALT:                        state_n = ST_HALT;
               default:                        state_n = ST_FETCH;
            endcase
         end
         ST_EXEC:   state_n = is_alu_op(ir[7:4]) ? ST_WB : ST_FETCH;
         ST_WB:     state_n = ST_FETCH;
         ST_TFETCH: state_n = ST_TARGET;
         ST_TARGET: state_n = ST_FETCH;
         ST_HALT:   state_n = ST_HALT;
         default:   state_n = ST_FETCH;
      endcase
   end

   simplex8_decode u_decode (
      .state   (state),
      .op      (ir[7:4]),
      .ctrl    (ctrl),
      .opnd_en (opnd_en),
      .imm_en  (imm_en)
   );

   assign PC_ADDR   = pc;
   assign ADD       = ctrl.add;
   assign SUB       = ctrl.sub;
   assign SHIFT     = ctrl.shift;
   assign OR        = ctrl.op_or;
   assign AND       = ctrl.op_and;
   assign SET_FLAGS = ctrl.set_flags;
   assign REG_WE    = ctrl.reg_we;
   assign ACC_WE    = ctrl.acc_we;
   assign ACC_SRC   = ctrl.acc_src;
   assign HALTED    = ctrl.halted;
   assign REG_SEL   = opnd_en ? REG_IDX_W'(ir[3:0]) : '0;
   assign IMM       = imm_en ? {4'b0000, ir[3:0]} : 8'h00;
   assign dbg_state = state;

endmodule
